// File: rtl/setclr_flagbank.sv
// Purpose: bank of sticky set/clear status flags with overflow tracking and one masked interrupt request.
// Latency: an event sets the flag after 1 cycle; o_irq follows the flags one cycle later (2 cycles from the event).
// Backpressure: none; events and clear strobes are taken every cycle and never stalled.
module setclr_flagbank #(
    parameter int N_FLAG   = 8,   // number of flags, 1..32
    parameter int PRIORITY = 0,   // set+clr collision: 0 set wins, 1 clr wins, 2 hold, 3 toggle
    parameter int EDGE     = 1    // 1: set on rising edge of the event, 0: set on level
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [N_FLAG-1:0] i_evt,
    input  logic              i_clrStrobe,
    input  logic [N_FLAG-1:0] i_clrMask,
    input  logic [N_FLAG-1:0] i_intEn,
    output logic [N_FLAG-1:0] o_flag,
    output logic [N_FLAG-1:0] o_ovf,
    output logic              o_irq
);

    typedef enum logic {
        FLAG_IDLE = 1'b0,
        FLAG_SET  = 1'b1
    } flag_state_e;

    // Collision outcome decoded once: from IDLE the flag goes up when set wins or toggles;
    // from SET it goes down when clr wins or toggles. PRIORITY=2 does neither (hold).
    localparam bit COLL_SET_FROM_IDLE = (PRIORITY == 0) || (PRIORITY == 3);
    localparam bit COLL_CLR_FROM_SET  = (PRIORITY == 1) || (PRIORITY == 3);

    logic [N_FLAG-1:0] evt_prev;
    logic [N_FLAG-1:0] set_vec;
    logic [N_FLAG-1:0] clr_vec;

    // Previous event level for edge detection; cleared by reset so a level already high counts as an edge.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            evt_prev <= '0;
        end else begin
            evt_prev <= i_evt;
        end
    end

    // Qualified set and write-1-to-clear requests for every flag.
    always_comb begin
        set_vec = (EDGE != 0) ? (i_evt & ~evt_prev) : i_evt;
        clr_vec = i_clrStrobe ? i_clrMask : '0;
    end

    for (genvar g = 0; g < N_FLAG; g++) begin : g_flag
        flag_state_e state_q;
        flag_state_e state_d;
        logic        ovf_q;
        logic        ovf_d;

        // Per-flag state and overflow registers.
        always_ff @(posedge i_clk) begin
            if (i_rst) begin
                state_q <= FLAG_IDLE;
                ovf_q   <= 1'b0;
            end else begin
                state_q <= state_d;
                ovf_q   <= ovf_d;
            end
        end

        // Next state: set/clr resolution, and overflow that is kept when a fresh overflow meets a clear.
        always_comb begin
            state_d = state_q;
            ovf_d   = (set_vec[g] && (state_q == FLAG_SET)) || (ovf_q && !clr_vec[g]);
            case (state_q)
                FLAG_IDLE: begin
                    if (set_vec[g] && (!clr_vec[g] || COLL_SET_FROM_IDLE)) begin
                        state_d = FLAG_SET;
                    end
                end
                FLAG_SET: begin
                    if (clr_vec[g] && (!set_vec[g] || COLL_CLR_FROM_SET)) begin
                        state_d = FLAG_IDLE;
                    end
                end
                default: state_d = FLAG_IDLE;
            endcase
        end

        assign o_flag[g] = (state_q == FLAG_SET);
        assign o_ovf[g]  = ovf_q;
    end

    // Interrupt request is the registered OR of enabled flags (level, no pulse mode).
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_irq <= 1'b0;
        end else begin
            o_irq <= |(o_flag & i_intEn);
        end
    end

endmodule

// File: tb/tb_setclr_flagbank.sv
// Bench for setclr_flagbank: table of vectors on the default instance, plus hand sequences
// for the PRIORITY sweep, level-mode overflow and level-mode toggling.
// Instances 0..3: EDGE=1 with PRIORITY 0..3; instance 4: EDGE=0 PRIORITY=0; instance 5: EDGE=0 PRIORITY=3.
module tb_setclr_flagbank;

    logic       clk;
    logic       rst;
    logic [7:0] evt;
    logic       stb;
    logic [7:0] mask;
    logic [7:0] en;

    logic [7:0] flag_p [6];
    logic [7:0] ovf_p  [6];
    logic       irq_p  [6];

    int n_tests = 0;
    int n_fail  = 0;

    for (genvar i = 0; i < 6; i++) begin : g_dut
        setclr_flagbank #(
            .N_FLAG  (8),
            .PRIORITY((i < 4) ? i : ((i == 4) ? 0 : 3)),
            .EDGE    ((i < 4) ? 1 : 0)
        ) u_dut (
            .i_clk      (clk),
            .i_rst      (rst),
            .i_evt      (evt),
            .i_clrStrobe(stb),
            .i_clrMask  (mask),
            .i_intEn    (en),
            .o_flag     (flag_p[i]),
            .o_ovf      (ovf_p[i]),
            .o_irq      (irq_p[i])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic [7:0] evt;
        logic       stb;
        logic [7:0] mask;
        logic [7:0] en;
        logic [7:0] eflag;
        logic [7:0] eovf;
        logic       eirq;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic r, input logic [7:0] e, input logic s, input logic [7:0] m,
                                input logic [7:0] ie, input logic [7:0] ef, input logic [7:0] eo,
                                input logic ei);
        vec_t v;
        v.rst = r; v.evt = e; v.stb = s; v.mask = m; v.en = ie;
        v.eflag = ef; v.eovf = eo; v.eirq = ei;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs, then land 1 time unit after the active edge.
    task automatic step(input logic r, input logic [7:0] e, input logic s, input logic [7:0] m,
                        input logic [7:0] ie);
        rst = r; evt = e; stb = s; mask = m; en = ie;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [3:0] q0_exp;
        logic [3:0] q1_exp;
        logic [3:0] tog_exp;

        rst = 1'b1; evt = '0; stb = 1'b0; mask = '0; en = '0;

        //            rst evt    stb mask   en     flag   ovf    irq
        vecs.push_back(mk(1, 8'hFF, 0, 8'h00, 8'h00, 8'h00, 8'h00, 0)); // reset with events high
        vecs.push_back(mk(1, 8'hFF, 0, 8'h00, 8'h00, 8'h00, 8'h00, 0));
        vecs.push_back(mk(0, 8'hFF, 0, 8'h00, 8'h00, 8'hFF, 8'h00, 0)); // level high after reset = edge
        vecs.push_back(mk(0, 8'hFF, 0, 8'h00, 8'h00, 8'hFF, 8'h00, 0)); // held high: no ovf
        vecs.push_back(mk(0, 8'h00, 1, 8'hF0, 8'h00, 8'h0F, 8'h00, 0));
        vecs.push_back(mk(0, 8'h00, 0, 8'h05, 8'h00, 8'h0F, 8'h00, 0)); // mask without strobe
        vecs.push_back(mk(0, 8'h00, 1, 8'h05, 8'h00, 8'h0A, 8'h00, 0)); // W1C
        vecs.push_back(mk(0, 8'h00, 1, 8'hFF, 8'h00, 8'h00, 8'h00, 0));
        vecs.push_back(mk(0, 8'h01, 0, 8'h00, 8'h01, 8'h01, 8'h00, 0)); // edge at t: flag at t+1
        vecs.push_back(mk(0, 8'h01, 0, 8'h00, 8'h01, 8'h01, 8'h00, 1)); // irq at t+2
        vecs.push_back(mk(0, 8'h01, 0, 8'h00, 8'h01, 8'h01, 8'h00, 1));
        vecs.push_back(mk(0, 8'h01, 0, 8'h00, 8'h01, 8'h01, 8'h00, 1));
        vecs.push_back(mk(0, 8'h01, 0, 8'h00, 8'h01, 8'h01, 8'h00, 1));
        vecs.push_back(mk(0, 8'h00, 0, 8'h00, 8'h01, 8'h01, 8'h00, 1)); // level irq stays high
        vecs.push_back(mk(0, 8'h00, 0, 8'h00, 8'h00, 8'h01, 8'h00, 0)); // enable drop, one cycle later
        vecs.push_back(mk(0, 8'h00, 0, 8'h00, 8'h02, 8'h01, 8'h00, 0)); // enable on unset flag
        vecs.push_back(mk(0, 8'h08, 0, 8'h00, 8'h00, 8'h09, 8'h00, 0));
        vecs.push_back(mk(0, 8'h00, 0, 8'h00, 8'h00, 8'h09, 8'h00, 0));
        vecs.push_back(mk(0, 8'h08, 0, 8'h00, 8'h00, 8'h09, 8'h08, 0)); // edge on set flag: ovf
        vecs.push_back(mk(0, 8'h00, 0, 8'h00, 8'h00, 8'h09, 8'h08, 0));
        vecs.push_back(mk(0, 8'h08, 1, 8'h08, 8'h00, 8'h09, 8'h08, 0)); // clr + edge: set wins, ovf kept
        vecs.push_back(mk(0, 8'h00, 1, 8'h08, 8'h00, 8'h01, 8'h00, 0)); // clr alone clears both
        vecs.push_back(mk(0, 8'h00, 1, 8'hFF, 8'h00, 8'h00, 8'h00, 0));
        vecs.push_back(mk(0, 8'hAA, 0, 8'h00, 8'hFF, 8'hAA, 8'h00, 0));
        vecs.push_back(mk(0, 8'h00, 0, 8'h00, 8'hFF, 8'hAA, 8'h00, 1));
        vecs.push_back(mk(0, 8'h02, 0, 8'h00, 8'hFF, 8'hAA, 8'h02, 1));
        vecs.push_back(mk(0, 8'h00, 0, 8'h00, 8'hFF, 8'hAA, 8'h02, 1));
        vecs.push_back(mk(1, 8'h55, 1, 8'hFF, 8'hFF, 8'h00, 8'h00, 0)); // reset beats strobe and events
        vecs.push_back(mk(0, 8'h00, 0, 8'h00, 8'hFF, 8'h00, 8'h00, 0)); // nothing leaked through
        vecs.push_back(mk(0, 8'h55, 0, 8'h00, 8'hFF, 8'h55, 8'h00, 0));
        vecs.push_back(mk(0, 8'h00, 0, 8'h00, 8'hFF, 8'h55, 8'h00, 1));

        foreach (vecs[k]) begin
            step(vecs[k].rst, vecs[k].evt, vecs[k].stb, vecs[k].mask, vecs[k].en);
            check($sformatf("row%0d.flag", k), {24'h0, flag_p[0]}, {24'h0, vecs[k].eflag});
            check($sformatf("row%0d.ovf", k),  {24'h0, ovf_p[0]},  {24'h0, vecs[k].eovf});
            check($sformatf("row%0d.irq", k),  {31'h0, irq_p[0]},  {31'h0, vecs[k].eirq});
        end

        // Priority sweep on flag 1: expected next q per PRIORITY, bit p = instance p.
        q0_exp = 4'b1001;
        q1_exp = 4'b0101;
        step(1, 8'h00, 0, 8'h00, 8'h00);
        step(0, 8'h02, 1, 8'h02, 8'h00);
        for (int p = 0; p < 4; p++) begin
            check($sformatf("prio%0d.from0.flag1", p), {31'h0, flag_p[p][1]}, {31'h0, q0_exp[p]});
            check($sformatf("prio%0d.from0.ovf", p), {24'h0, ovf_p[p]}, 32'h0);
        end
        step(0, 8'h00, 0, 8'h00, 8'h00);
        step(0, 8'h02, 0, 8'h00, 8'h00);
        for (int p = 0; p < 4; p++) begin
            check($sformatf("prio%0d.preset.flag1", p), {31'h0, flag_p[p][1]}, 32'h1);
        end
        step(0, 8'h00, 0, 8'h00, 8'h00);
        step(0, 8'h02, 1, 8'h02, 8'h00);
        for (int p = 0; p < 4; p++) begin
            check($sformatf("prio%0d.from1.flag1", p), {31'h0, flag_p[p][1]}, {31'h0, q1_exp[p]});
        end

        // Level mode held high: ovf from the second cycle; edge mode sets once with no ovf.
        step(1, 8'h00, 0, 8'h00, 8'h00);
        step(0, 8'h01, 0, 8'h00, 8'h00);
        check("lvl.c1.flag", {24'h0, flag_p[4]}, 32'h01);
        check("lvl.c1.ovf",  {24'h0, ovf_p[4]},  32'h00);
        step(0, 8'h01, 0, 8'h00, 8'h00);
        check("lvl.c2.ovf",  {24'h0, ovf_p[4]},  32'h01);
        step(0, 8'h01, 0, 8'h00, 8'h00);
        check("lvl.c3.flag", {24'h0, flag_p[4]}, 32'h01);
        check("lvl.c3.ovf",  {24'h0, ovf_p[4]},  32'h01);
        check("edge.held.ovf", {24'h0, ovf_p[0]}, 32'h00);

        // Level mode with toggle priority and persistent set+clr: flag alternates every cycle.
        tog_exp = 4'b0101;
        step(1, 8'h00, 0, 8'h00, 8'h00);
        for (int c = 0; c < 4; c++) begin
            step(0, 8'h01, 1, 8'h01, 8'h00);
            check($sformatf("toggle.c%0d.flag0", c), {31'h0, flag_p[5][0]}, {31'h0, tog_exp[c]});
            check($sformatf("toggle.c%0d.lvl_setwins", c), {24'h0, flag_p[4]}, 32'h01);
        end
        for (int i = 0; i < 6; i++) begin
            check($sformatf("inst%0d.irq_disabled", i), {31'h0, irq_p[i]}, 32'h0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/setclr_flagbank.md
Name: setclr_flagbank

Overview:
- Bank of N_FLAG sticky status flags, each a 1b set/clr FSM.
- Hardware events set the flags, optionally through rising-edge detection.
- Software clears flags with a masked write-1-to-clear strobe.
- Sits directly downstream of event sources and upstream of the interrupt controller. Provides per-flag overflow tracking and one registered, masked interrupt request.

Parameters:
- N_FLAG, 8, number of flags; legal range 1..32.
- PRIORITY, 0, resolution when set and clr coincide on one flag: 0 = set wins, 1 = clr wins, 2 = no change, 3 = toggle.
- EDGE, 1, 1 = set on rising edge of i_evt[i]; 0 = set whenever i_evt[i] is high (level).

Ports:
- i_clk  input  1  clock; all state updates on rising edge.
- i_rst  input  1  synchronous, active-high reset.
- i_evt  input  N_FLAG  raw event inputs, synchronous to i_clk.
- i_clrStrobe  input  1  software clear strobe, single cycle.
- i_clrMask  input  N_FLAG  write-1-to-clear mask, qualified by i_clrStrobe.
- i_intEn  input  N_FLAG  per-flag interrupt enable.
- o_flag  output  N_FLAG  sticky flag state.
- o_ovf  output  N_FLAG  sticky overflow: an event arrived while the flag was already set.
- o_irq  output  1  registered interrupt request.

Behaviour:
- Reset: clock is i_clk; reset is i_rst, synchronous, active-high. When i_rst=1 at a rising edge, the following are all zero:
  - o_flag = 0, o_ovf = 0, o_irq = 0.
  - evtPrev = 0.
- Reset priority: i_rst overrides all other inputs in the same cycle. Events and strobes in a reset cycle are discarded.
- Event qualification:
  - evtPrev[i] <= i_evt[i] every cycle.
  - EDGE=1: set[i] = i_evt[i] && !evtPrev[i].
  - EDGE=0: set[i] = i_evt[i].
  - Because evtPrev resets to 0, an i_evt level already high in the first post-reset cycle counts as an edge.
- Clear qualification: clr[i] = i_clrStrobe && i_clrMask[i]. A mask with i_clrStrobe=0 has no effect.
- Flag next state, per bit, registered with 1-cycle latency:
  - set && !clr → 1.
  - clr && !set → 0.
  - neither → hold.
  - set && clr → 1 / 0 / hold / invert for PRIORITY = 0 / 1 / 2 / 3.
- Overflow next state: ovf[i]_d = (set[i] && flag[i]_q) || (ovf[i]_q && !clr[i]).
  - flag[i]_q is the current registered flag, before this cycle's update.
  - A new overflow coinciding with clr is retained, so an event is never silently lost.
  - clr clears flag and ovf of the same bit together.
- IRQ: o_irq <= |(o_flag & i_intEn), registered.
  - Latency from a qualifying i_evt edge at cycle t: o_flag at t+1, o_irq at t+2.
  - A change in i_intEn affects o_irq one cycle later.
  - There is no irq edge or pulse mode; o_irq is a level that stays high while any enabled flag is set.
- Independence: flags are fully independent per bit. No cross-bit priority and no ordering.
- Boundaries:
  - EDGE=1, i_evt held high for many cycles: sets once only; no ovf.
  - EDGE=0, i_evt held high: flag set every cycle, so o_ovf sets from the second cycle onward.
  - Simultaneous clr and fresh event on a flag that is currently 0: resolved by PRIORITY; ovf unaffected (flag_q was 0).
  - PRIORITY=3 with EDGE=0 and persistent set+clr: flag alternates every cycle (defined behaviour, not an error).
- Datapath: all bitwise, no arithmetic. No X propagation on outputs after the first reset. Output values are undefined before the first reset.

Test Plan:
- Reset and idle: i_rst=1 for 2 cycles with i_evt=8'hFF, then i_rst=0, EDGE=1 → o_flag=8'hFF one cycle after reset release; o_irq=0 while i_intEn=0.
- Edge set and irq latency: i_intEn=8'h01; i_evt[0] rises at cycle t and is held 5 cycles → o_flag[0]=1 at t+1, o_irq=1 at t+2; o_ovf[0] stays 0.
- W1C clear: with o_flag=8'h0F, pulse i_clrStrobe=1 with i_clrMask=8'h05 → o_flag=8'h0A next cycle. The same mask with i_clrStrobe=0 → no change.
- Overflow: flag[3]=1, new edge on i_evt[3] → o_ovf[3]=1. Next, clr[3] coinciding with another edge → flag[3] per PRIORITY, o_ovf[3] stays 1. Then clr[3] alone → o_flag[3]=0, o_ovf[3]=0.
- Priority sweep: for PRIORITY 0..3, drive simultaneous set and clr on flag 1 from q=0 and from q=1 → next q = {1,1} / {0,0} / {0,1} / {1,0} respectively.
- Reset mid-operation: flags 8'hAA, o_ovf 8'h02, o_irq=1; assert i_rst coincident with i_clrStrobe and new events → all outputs 0 next cycle, and no set from those events.
